// File: rtl/memory_ctrl_pkg.sv
// ============================================================================
// Module      : memory_ctrl_pkg
// Description : Shared types and constants for the memory sequencing
//               controller: FSM state encoding, command codes and default
//               datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_ctrl_pkg;

  // Default datapath geometry: 32-bit words, 64-entry RAM
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  // Command codes presented on mc_data_contition; 3'b100..3'b111 are reserved
  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_WR     = 3'b001;
  localparam logic [2:0] CMD_RD     = 3'b010;
  localparam logic [2:0] CMD_CLRPTR = 3'b011;

  // Controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_RD_A   = 3'd3,
    ST_RD_B   = 3'd4,
    ST_RD_CAP = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/memory_ctrl.sv
// ============================================================================
// Module      : memory_ctrl
// Description : Sequencing controller between a datapath and a companion
//               single_port_ram (registered read, 1-cycle latency). Stores
//               1-2 words at an auto-incrementing write pointer, fetches 1-2
//               operands (opa/opb) from an auto-incrementing read pointer and
//               reports completion through a mc_done / mc_data_done handshake.
//               Optional feature macro MC_ERR_EN adds the mc_err output, a
//               one-cycle pulse after a reserved command is sampled in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic [2:0]        mc_data_contition,
  input  logic              mc_data_length,
  input  logic [DATA_W-1:0] mc_data_in,
  input  logic              mc_data_done,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W-1:0] mc_address_mem,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mc_we,
  output logic [DATA_W-1:0] mc_data_out_opa,
  output logic [DATA_W-1:0] mc_data_out_opb,
  output logic              mc_done
`ifdef MC_ERR_EN
  ,
  output logic              mc_err
`endif
);

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  // Word count of the command in flight, frozen at accept so a changing
  // mc_data_length mid-command cannot corrupt the sequence.
  logic              len_two;

  // Pointer offsets kept at address width so wrap-around is natural
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_TWO = ADDR_W'(2);

  // State register; asynchronous reset drops any write immediately
  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; commands are only looked at in IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        case (mc_data_contition)
          CMD_NOP:    state_next = ST_IDLE;
          CMD_WR:     state_next = ST_WR_A;
          CMD_RD:     state_next = ST_RD_A;
          CMD_CLRPTR: state_next = ST_DONE;
          default:    state_next = ST_IDLE;
        endcase
      end
      ST_WR_A:   state_next = len_two ? ST_WR_B : ST_DONE;
      ST_WR_B:   state_next = ST_DONE;
      ST_RD_A:   state_next = len_two ? ST_RD_B : ST_RD_CAP;
      ST_RD_B:   state_next = ST_RD_CAP;
      ST_RD_CAP: state_next = ST_DONE;
      ST_DONE:   state_next = mc_data_done ? ST_IDLE : ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode from registered state and pointers only
  always_comb begin
    mc_we          = 1'b0;
    mc_address_mem = '0;
    mc_done        = 1'b0;
    case (state)
      ST_WR_A: begin
        mc_we          = 1'b1;
        mc_address_mem = wr_ptr;
      end
      ST_WR_B: begin
        mc_we          = 1'b1;
        mc_address_mem = wr_ptr + PTR_ONE;
      end
      ST_RD_A:   mc_address_mem = rd_ptr;
      ST_RD_B:   mc_address_mem = rd_ptr + PTR_ONE;
      // Keep pointing at the last word fetched while its data is captured
      ST_RD_CAP: mc_address_mem = len_two ? (rd_ptr + PTR_ONE) : rd_ptr;
      ST_DONE:   mc_done = 1'b1;
      default: begin
        mc_we          = 1'b0;
        mc_address_mem = '0;
        mc_done        = 1'b0;
      end
    endcase
  end

  // The write-data register drives the RAM in every state; only mc_we qualifies it
  assign mem_data_in     = wdata;
  assign mc_data_out_opa = opa;
  assign mc_data_out_opb = opb;

  // Pointer, write-data and operand registers advanced by the sequence
  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wdata   <= '0;
      opa     <= '0;
      opb     <= '0;
      len_two <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mc_data_contition == CMD_WR) begin
            wdata   <= mc_data_in;
            len_two <= mc_data_length;
          end else if (mc_data_contition == CMD_RD) begin
            len_two <= mc_data_length;
          end else if (mc_data_contition == CMD_CLRPTR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        ST_WR_A: begin
          // Second word is latched here so WR_B writes it; single-word ends now
          if (len_two) begin
            wdata <= mc_data_in;
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
          end
        end
        ST_WR_B: begin
          wr_ptr <= wr_ptr + PTR_TWO;
        end
        ST_RD_B: begin
          // RAM now returns the word addressed in RD_A
          opa <= mem_data_out;
        end
        ST_RD_CAP: begin
          if (len_two) begin
            opb    <= mem_data_out;
            rd_ptr <= rd_ptr + PTR_TWO;
          end else begin
            opa    <= mem_data_out;
            rd_ptr <= rd_ptr + PTR_ONE;
          end
        end
        default: begin
          wr_ptr <= wr_ptr;
        end
      endcase
    end
  end

`ifdef MC_ERR_EN
  // One-cycle error flag for each reserved command sampled while idle
  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      mc_err <= 1'b0;
    end else begin
      mc_err <= (state == ST_IDLE) && mc_data_contition[2];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_ctrl.sv
// ============================================================================
// Module      : tb_memory_ctrl
// Description : Self-checking bench for memory_ctrl with a behavioural RAM
//               beside the DUT and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_ctrl;
  import memory_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cmd = 3'b000;
  logic        len = 1'b0;
  logic [31:0] din = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  addr;
  logic [31:0] md;
  logic        we;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        done;
`ifdef MC_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  memory_ctrl dut (
    .mc_clk            (clk),
    .mc_reset          (rst_n),
    .mc_data_contition (cmd),
    .mc_data_length    (len),
    .mc_data_in        (din),
    .mc_data_done      (ack),
    .mem_data_out      (rdata),
    .mc_address_mem    (addr),
    .mem_data_in       (md),
    .mc_we             (we),
    .mc_data_out_opa   (opa),
    .mc_data_out_opb   (opb),
    .mc_done           (done)
`ifdef MC_ERR_EN
    ,
    .mc_err            (err)
`endif
  );

  // Companion single-port RAM: synchronous write, registered read, no reset
  logic [31:0] ram [0:63];
  initial for (int i = 0; i < 64; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (we) ram[addr] <= md;
    rdata <= ram[addr];
  end

  // Reference model: architectural state of the controller
  logic [31:0] m_mem [0:63];
  logic [5:0]  m_wr = '0;
  logic [5:0]  m_rd = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_opa = '0;
  logic [31:0] m_opb = '0;
  initial for (int i = 0; i < 64; i++) m_mem[i] = '0;

  // Expected outputs for each cycle of a command; empty queue means idle
  typedef struct {
    bit          chk_addr;
    bit          we;
    bit          done;
    logic [5:0]  addr;
    logic [31:0] md;
    logic [31:0] opa;
    logic [31:0] opb;
  } exp_t;
  exp_t expq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit ca, input bit w, input bit dn, input logic [5:0] a,
                      input logic [31:0] d, input logic [31:0] oa, input logic [31:0] ob);
    exp_t e;
    e.chk_addr = ca; e.we = w; e.done = dn; e.addr = a;
    e.md = d; e.opa = oa; e.opb = ob;
    expq.push_back(e);
  endtask

  // Single compare process, one sample per cycle just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
        end else begin
          e.chk_addr = 1'b1; e.we = 1'b0; e.done = 1'b0; e.addr = '0;
          e.md = m_wdata; e.opa = m_opa; e.opb = m_opb;
        end
        check("we", {31'b0, we}, {31'b0, e.we});
        check("done", {31'b0, done}, {31'b0, e.done});
        if (e.chk_addr) check("addr", {26'b0, addr}, {26'b0, e.addr});
        check("mem_data_in", md, e.md);
        check("opa", opa, e.opa);
        check("opb", opb, e.opb);
      end
    end
  end

  // Issue one command, keep DONE for hold extra cycles (driving noise), then ack
  task automatic run_cmd(input logic [2:0] c, input logic l, input logic [31:0] d0,
                         input logic [31:0] d1, input int hold, input logic [2:0] noise);
    int          n_act;
    logic [5:0]  p;
    logic [5:0]  p1;
    logic [31:0] oa;
    logic [31:0] ob;
    @(negedge clk);
    cmd = c; len = l; din = d0;
    oa = m_opa; ob = m_opb; n_act = 0;
    p = '0;
    case (c)
      CMD_WR: begin
        p = m_wr; p1 = p + 6'd1;
        push(1, 1, 0, p, d0, oa, ob);
        m_mem[p] = d0; m_wdata = d0; n_act = 1;
        if (l) begin
          push(1, 1, 0, p1, d1, oa, ob);
          m_mem[p1] = d1; m_wdata = d1; n_act = 2;
        end
        m_wr = m_wr + (l ? 6'd2 : 6'd1);
      end
      CMD_RD: begin
        p = m_rd; p1 = p + 6'd1;
        push(1, 0, 0, p, m_wdata, oa, ob);
        if (l) begin
          push(1, 0, 0, p1, m_wdata, oa, ob);
          push(0, 0, 0, '0, m_wdata, m_mem[p], ob);
          m_opa = m_mem[p]; m_opb = m_mem[p1]; n_act = 3;
          m_rd = p + 6'd2;
        end else begin
          push(0, 0, 0, '0, m_wdata, oa, ob);
          m_opa = m_mem[p]; n_act = 2;
          m_rd = p1;
        end
      end
      CMD_CLRPTR: begin
        m_wr = '0; m_rd = '0;
      end
      default: n_act = 0;
    endcase
    for (int i = 0; i <= hold; i++) push(1, 0, 1, '0, m_wdata, m_opa, m_opb);
    @(negedge clk);
    cmd = CMD_NOP; din = d1;
    repeat (n_act) @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      cmd = noise;
      @(negedge clk);
    end
    cmd = CMD_NOP; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // A command that must leave the controller idle
  task automatic idle_cmd(input logic [2:0] c);
    @(negedge clk);
    cmd = c;
    @(negedge clk);
    cmd = CMD_NOP;
`ifdef MC_ERR_EN
    check("err_pulse", {31'b0, err}, {31'b0, c[2]});
    @(negedge clk);
    check("err_clear", {31'b0, err}, 32'd0);
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_addr", {26'b0, addr}, 32'd0);
    check("rst_opa", opa, 32'd0);
    check("rst_opb", opb, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset in the middle of WR_A aborts the write at once
    @(negedge clk);
    cmd = CMD_WR; len = 1'b0; din = 32'h1111_1111;
    push(1, 1, 0, 6'd0, 32'h1111_1111, '0, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'b0, we}, 32'd0);
    check("abort_addr", {26'b0, addr}, 32'd0);
    check("abort_md", md, 32'd0);
    @(negedge clk);
    cmd = CMD_NOP;
    @(posedge clk);
    #1;
    check("abort_no_write", ram[0], 32'd0);
    @(negedge clk);
    expq.delete();
    m_wr = '0; m_rd = '0; m_wdata = '0; m_opa = '0; m_opb = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // 2: two-word write then two-word read
    run_cmd(CMD_WR, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 0, CMD_NOP);
    run_cmd(CMD_RD, 1'b1, 32'h0, 32'h0, 0, CMD_NOP);
    check("t2_opa", opa, 32'hDEAD_BEEF);
    check("t2_opb", opb, 32'h1234_5678);

    // 3: single-word write/read after pointer clear; opb untouched
    run_cmd(CMD_CLRPTR, 1'b0, 32'h0, 32'h0, 1, CMD_NOP);
    run_cmd(CMD_WR, 1'b0, 32'hA5A5_A5A5, 32'h0, 0, CMD_NOP);
    run_cmd(CMD_RD, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    check("t3_opa", opa, 32'hA5A5_A5A5);
    check("t3_opb", opb, 32'h1234_5678);
    run_cmd(CMD_RD, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    check("t3_rdptr1", opa, 32'h1234_5678);

    // 4: walk write pointer to 63, then two-word write wraps to address 0
    for (int i = 1; i <= 62; i++) run_cmd(CMD_WR, 1'b0, 32'h100 + i, 32'h0, 0, CMD_NOP);
    run_cmd(CMD_WR, 1'b1, 32'hCAFE_F00D, 32'h0BAD_C0DE, 0, CMD_NOP);
    check("t4_ram63", ram[63], 32'hCAFE_F00D);
    check("t4_ram0", ram[0], 32'h0BAD_C0DE);
    run_cmd(CMD_WR, 1'b0, 32'h5555_0001, 32'h0, 0, CMD_NOP);
    check("t4_wrptr1", ram[1], 32'h5555_0001);
    for (int i = 0; i < 30; i++) run_cmd(CMD_RD, 1'b1, 32'h0, 32'h0, 0, CMD_NOP);
    run_cmd(CMD_RD, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    check("t4_rd62", opa, 32'h0000_013E);
    run_cmd(CMD_RD, 1'b1, 32'h0, 32'h0, 0, CMD_NOP);
    check("t4_wrap_opa", opa, 32'hCAFE_F00D);
    check("t4_wrap_opb", opb, 32'h0BAD_C0DE);

    // 5: DONE held for 5 cycles while a read command is presented
    run_cmd(CMD_WR, 1'b0, 32'h7777_7777, 32'h0, 5, CMD_RD);

    // 6: pointer clear then read of address 0; reserved command is inert
    run_cmd(CMD_CLRPTR, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    run_cmd(CMD_RD, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    check("t6_rd0", opa, 32'h0BAD_C0DE);
    idle_cmd(3'b101);
    run_cmd(CMD_RD, 1'b0, 32'h0, 32'h0, 0, CMD_NOP);
    check("t6_rd1", opa, 32'h5555_0001);

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
